// File: rtl/uc_secuenciador_if.sv
// Datapath-facing bundle of the control unit: opcode/flag in, datapath controls out.
// The datapath is the master side, the sequencer is the slave side.
interface uc_secuenciador_if;
   logic [5:0] Opcode;
   logic       z;
   logic       s_inc;
   logic       s_inm;
   logic       we3;
   logic       wez;
   logic [2:0] Op;
   logic       pc_we;

   modport master (
      output Opcode,
      output z,
      input  s_inc,
      input  s_inm,
      input  we3,
      input  wez,
      input  Op,
      input  pc_we
   );

   modport slave (
      input  Opcode,
      input  z,
      output s_inc,
      output s_inm,
      output we3,
      output wez,
      output Op,
      output pc_we
   );
endinterface

// File: rtl/uc_secuenciador.sv
// Control unit for the single-cycle microcontroller: opcode decode, debug
// run/halt/single-step sequencer and retired-instruction counter.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_BOOT | first cycle after reset, nothing executes
//   ST_RUN  | free-running, one instruction retired per cycle
//   ST_HALT | stopped, PC and register writes frozen
//   ST_STEP | executes exactly one instruction, then back to ST_HALT
module uc_secuenciador #(
   parameter int CNT_W        = 16,
   parameter bit START_HALTED = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   uc_secuenciador_if.slave dp,
   input  logic             dbg_halt,
   input  logic             dbg_run,
   input  logic             dbg_step,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2,
      ST_STEP = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic       dec_s_inc;
   logic       dec_s_inm;
   logic [2:0] dec_op;
   logic       dec_we3;
   logic       dec_wez;
   logic       dec_pc_we;
   logic       dec_illegal;
   logic       dec_halt;
   logic       exec;

   // Instruction decode, independent of the sequencer state.
   always_comb begin
      dec_s_inc   = 1'b1;
      dec_s_inm   = 1'b0;
      dec_op      = 3'b000;
      dec_we3     = 1'b0;
      dec_wez     = 1'b0;
      dec_pc_we   = 1'b1;
      dec_illegal = 1'b0;
      dec_halt    = 1'b0;
      casez (dp.Opcode)
         6'b1?????: begin
            dec_s_inm = 1'b1;
            dec_op    = dp.Opcode[4:2];
            dec_we3   = 1'b1;
            dec_wez   = 1'b1;
         end
         6'b01????: begin
            dec_op  = dp.Opcode[3:1];
            dec_we3 = 1'b1;
            dec_wez = 1'b1;
         end
         6'b000000: dec_s_inc = 1'b0;
         6'b000001: dec_s_inc = ~dp.z;
         6'b000010: dec_s_inc = dp.z;
         6'b000011: dec_halt  = 1'b1;
         default:   dec_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_BOOT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_BOOT: state_nxt = START_HALTED ? ST_HALT : ST_RUN;
         ST_RUN:  state_nxt = (dbg_halt || dec_halt) ? ST_HALT : ST_RUN;
         ST_HALT: begin
            if (dbg_halt) begin
               state_nxt = ST_HALT;
            end else if (dbg_step) begin
               state_nxt = ST_STEP;
            end else if (dbg_run) begin
               state_nxt = ST_RUN;
            end else begin
               state_nxt = ST_HALT;
            end
         end
         ST_STEP: state_nxt = ST_HALT;
         default: state_nxt = ST_BOOT;
      endcase
   end

   // Reset in flight aborts the current instruction, so exec is also masked by reset.
   always_comb begin
      exec     = ((state == ST_RUN) || (state == ST_STEP)) && !reset;
      dp.s_inc = dec_s_inc;
      dp.s_inm = dec_s_inm;
      dp.Op    = dec_op;
      dp.we3   = dec_we3 & exec;
      dp.wez   = dec_wez & exec;
      dp.pc_we = dec_pc_we & exec;
      illegal  = dec_illegal & exec;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         halted <= 1'b0;
      end else begin
         halted <= (state_nxt == ST_HALT);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         instr_cnt <= '0;
      end else if (exec) begin
         instr_cnt <= instr_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_uc_secuenciador.sv
// Directed bench for uc_secuenciador: decode, jumps, halt/run/step sequencing,
// counter wrap and reset, with a START_HALTED and a narrow-counter instance.
module tb_uc_secuenciador;

   logic       clk = 1'b0;
   logic       reset;
   logic       rst_w;
   logic [5:0] opcode;
   logic       z;
   logic       dbg_halt, dbg_run, dbg_step;

   logic        halted_a, illegal_a;
   logic [15:0] cnt_a;
   logic        halted_h, illegal_h;
   logic [15:0] cnt_h;
   logic        halted_w, illegal_w;
   logic [3:0]  cnt_w;

   int n_pass = 0;
   int n_chk  = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   uc_secuenciador_if if_a ();
   uc_secuenciador_if if_h ();
   uc_secuenciador_if if_w ();

   assign if_a.Opcode = opcode;
   assign if_a.z      = z;
   assign if_h.Opcode = opcode;
   assign if_h.z      = z;
   assign if_w.Opcode = opcode;
   assign if_w.z      = z;

   uc_secuenciador #(.CNT_W(16), .START_HALTED(1'b0)) dut_a (
      .clk(clk), .reset(reset), .dp(if_a),
      .dbg_halt(dbg_halt), .dbg_run(dbg_run), .dbg_step(dbg_step),
      .halted(halted_a), .illegal(illegal_a), .instr_cnt(cnt_a)
   );

   uc_secuenciador #(.CNT_W(16), .START_HALTED(1'b1)) dut_h (
      .clk(clk), .reset(reset), .dp(if_h),
      .dbg_halt(dbg_halt), .dbg_run(dbg_run), .dbg_step(dbg_step),
      .halted(halted_h), .illegal(illegal_h), .instr_cnt(cnt_h)
   );

   uc_secuenciador #(.CNT_W(4), .START_HALTED(1'b0)) dut_w (
      .clk(clk), .reset(rst_w), .dp(if_w),
      .dbg_halt(1'b0), .dbg_run(1'b0), .dbg_step(1'b0),
      .halted(halted_w), .illegal(illegal_w), .instr_cnt(cnt_w)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // ex marks whether the cycle being closed is an executing cycle of dut_a.
   task automatic tick(input bit ex);
      if (ex) exp_cnt++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset    = 1'b1;
      rst_w    = 1'b1;
      opcode   = 6'b010000;
      z        = 1'b0;
      dbg_halt = 1'b0;
      dbg_run  = 1'b0;
      dbg_step = 1'b0;
      tick(0);
      tick(0);
      reset = 1'b0;
      #1;
      // BOOT cycle
      chk("boot_we3",   if_a.we3, 1'b0);
      chk("boot_wez",   if_a.wez, 1'b0);
      chk("boot_pc_we", if_a.pc_we, 1'b0);
      chk("boot_cnt",   cnt_a, 16'd0);
      chk("boot_halted", halted_a, 1'b0);
      tick(0);
      #1;
      chk("run_we3",   if_a.we3, 1'b1);
      chk("run_op",    if_a.Op, 3'b000);
      chk("run_pc_we", if_a.pc_we, 1'b1);
      chk("run_cnt0",  cnt_a, 16'd0);
      chk("sh_halted", halted_h, 1'b1);
      chk("sh_pc_we",  if_h.pc_we, 1'b0);
      tick(1);
      chk("run_cnt1",  cnt_a, exp_cnt);

      // ALU decode
      opcode = 6'b110100;
      #1;
      chk("imm_s_inm", if_a.s_inm, 1'b1);
      chk("imm_op",    if_a.Op, 3'b101);
      chk("imm_we3",   if_a.we3, 1'b1);
      chk("imm_wez",   if_a.wez, 1'b1);
      chk("imm_s_inc", if_a.s_inc, 1'b1);
      tick(1);
      opcode = 6'b011110;
      #1;
      chk("rr_s_inm", if_a.s_inm, 1'b0);
      chk("rr_op",    if_a.Op, 3'b111);
      chk("rr_we3",   if_a.we3, 1'b1);
      tick(1);
      opcode = 6'b000100;
      #1;
      chk("rsv_illegal", illegal_a, 1'b1);
      chk("rsv_we3",     if_a.we3, 1'b0);
      chk("rsv_wez",     if_a.wez, 1'b0);
      chk("rsv_pc_we",   if_a.pc_we, 1'b1);
      tick(1);

      // conditional and unconditional jumps
      opcode = 6'b000001;
      z = 1'b1;
      #1;
      chk("jz_z1",    if_a.s_inc, 1'b0);
      chk("jz_pc_we", if_a.pc_we, 1'b1);
      chk("jz_we3",   if_a.we3, 1'b0);
      chk("jz_ill",   illegal_a, 1'b0);
      z = 1'b0;
      #1;
      chk("jz_z0", if_a.s_inc, 1'b1);
      tick(1);
      opcode = 6'b000010;
      z = 1'b1;
      #1;
      chk("jnz_z1", if_a.s_inc, 1'b1);
      z = 1'b0;
      #1;
      chk("jnz_z0", if_a.s_inc, 1'b0);
      opcode = 6'b000000;
      #1;
      chk("j_s_inc", if_a.s_inc, 1'b0);
      tick(1);
      chk("cnt_after_dec", cnt_a, exp_cnt);

      // HALT opcode
      opcode = 6'b000011;
      #1;
      chk("hlt_pc_we", if_a.pc_we, 1'b1);
      chk("hlt_s_inc", if_a.s_inc, 1'b1);
      chk("hlt_we3",   if_a.we3, 1'b0);
      tick(1);
      opcode = 6'b010000;
      #1;
      chk("hlt_halted", halted_a, 1'b1);
      chk("hlt_pc_we0", if_a.pc_we, 1'b0);
      chk("hlt_we3_0",  if_a.we3, 1'b0);
      opcode = 6'b000100;
      #1;
      chk("hlt_no_ill", illegal_a, 1'b0);
      opcode = 6'b010000;
      for (int i = 0; i < 5; i++) tick(0);
      chk("hlt_frozen", cnt_a, exp_cnt);
      chk("hlt_still",  halted_a, 1'b1);

      // resume with a one-cycle run pulse
      dbg_run = 1'b1;
      tick(0);
      dbg_run = 1'b0;
      #1;
      chk("resume_halted", halted_a, 1'b0);
      chk("resume_pc_we",  if_a.pc_we, 1'b1);
      tick(1);

      // dbg_halt: the current instruction still executes
      dbg_halt = 1'b1;
      #1;
      chk("dbgh_we3", if_a.we3, 1'b1);
      tick(1);
      chk("dbgh_halted", halted_a, 1'b1);
      dbg_step = 1'b1;
      tick(0);
      chk("halt_over_step", halted_a, 1'b1);
      chk("halt_over_step_pc", if_a.pc_we, 1'b0);
      dbg_halt = 1'b0;
      dbg_step = 1'b0;
      tick(0);

      // single step
      dbg_step = 1'b1;
      tick(0);
      dbg_step = 1'b0;
      #1;
      chk("step_pc_we",  if_a.pc_we, 1'b1);
      chk("step_halted", halted_a, 1'b0);
      tick(1);
      chk("step_back", halted_a, 1'b1);
      chk("step_pc_we0", if_a.pc_we, 1'b0);
      chk("step_cnt", cnt_a, exp_cnt);

      // step beats run
      dbg_step = 1'b1;
      dbg_run  = 1'b1;
      tick(0);
      dbg_step = 1'b0;
      dbg_run  = 1'b0;
      #1;
      chk("sr_pc_we", if_a.pc_we, 1'b1);
      tick(1);
      chk("sr_halted", halted_a, 1'b1);
      tick(0);
      chk("sr_cnt", cnt_a, exp_cnt);

      // held step alternates STEP/HALT
      dbg_step = 1'b1;
      tick(0);
      chk("hold_s1", if_a.pc_we, 1'b1);
      tick(1);
      chk("hold_h1", if_a.pc_we, 1'b0);
      tick(0);
      chk("hold_s2", if_a.pc_we, 1'b1);
      tick(1);
      chk("hold_h2", halted_a, 1'b1);
      dbg_step = 1'b0;
      chk("hold_cnt", cnt_a, exp_cnt);

      // step ignored while running
      dbg_run = 1'b1;
      tick(0);
      dbg_run  = 1'b0;
      dbg_step = 1'b1;
      tick(1);
      chk("step_in_run", halted_a, 1'b0);
      chk("step_in_run_pc", if_a.pc_we, 1'b1);
      dbg_step = 1'b0;
      tick(1);
      chk("run_cnt", cnt_a, exp_cnt);

      // reset during RUN
      reset = 1'b1;
      tick(0);
      reset = 1'b0;
      exp_cnt = 0;
      #1;
      chk("rst_we3",   if_a.we3, 1'b0);
      chk("rst_pc_we", if_a.pc_we, 1'b0);
      chk("rst_cnt",   cnt_a, exp_cnt);
      chk("rst_halted", halted_a, 1'b0);

      // 4-bit counter wrap
      opcode = 6'b110000;
      rst_w  = 1'b0;
      tick(0);
      for (int i = 0; i < 17; i++) tick(0);
      chk("wrap_cnt", cnt_w, 4'd1);
      chk("wrap_we3", if_w.we3, 1'b1);
      rst_w = 1'b1;
      tick(0);
      rst_w = 1'b0;
      #1;
      chk("wrst_we3",   if_w.we3, 1'b0);
      chk("wrst_pc_we", if_w.pc_we, 1'b0);
      chk("wrst_cnt",   cnt_w, 4'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
